// File: rtl/comb_sweep_pkg.sv
// rtl/comb_sweep_pkg.sv - shared mode and state encodings for the comb_sweep sequencer
package comb_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_DESC = 2'd2;

endpackage

// File: rtl/comb_sweep_map.sv
// rtl/comb_sweep_map.sv - combinational step-index to pattern mapper (binary, Gray, descending)
module sweep_map
    import comb_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [1:0]      mode,
    input  logic [N_IN-1:0] idx,
    output logic [N_IN-1:0] pattern
);

    always_comb begin
        pattern = idx;
        case (mode)
            MODE_GRAY: pattern = idx ^ (idx >> 1);
            // 2^N-1-k is the bitwise complement within N bits
            MODE_DESC: pattern = ~idx;
            default:   pattern = idx;
        endcase
    end

endmodule

// File: rtl/comb_sweep.sv
// rtl/comb_sweep.sv - exhaustive stimulus sequencer that captures and checks a truth table
module comb_sweep
    import comb_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter int TT_W   = N_OUT << N_IN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [TT_W-1:0]  exp_tt,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TT_W-1:0]  tt
);

    localparam logic [N_IN:0] K_LAST   = (N_IN + 1)'((1 << N_IN) - 1);
    localparam logic [3:0]    SETTLE_C = 4'(SETTLE);

    state_t          state, next_state;
    logic [N_IN:0]   k;
    logic [N_IN:0]   k_inc;
    logic [3:0]      settle;
    logic [1:0]      mode_q;
    logic            pass_q;
    logic            sample;
    logic [1:0]      map_mode;
    logic [N_IN-1:0] map_idx;
    logic [N_IN-1:0] map_pattern;
    logic [TT_W-1:0] tt_wr;

    assign k_inc  = k + 1'b1;
    assign sample = (state == S_HOLD) && (settle == SETTLE_C);

    // In IDLE the mapper produces the first pattern from the live mode input
    assign map_mode = (state == S_IDLE) ? mode : mode_q;
    assign map_idx  = (state == S_IDLE) ? '0 : k_inc[N_IN-1:0];

    sweep_map #(.N_IN(N_IN)) u_map (
        .mode    (map_mode),
        .idx     (map_idx),
        .pattern (map_pattern)
    );

    always_comb begin
        tt_wr = tt;
        for (int v = 0; v < (1 << N_IN); v++) begin
            if (stim == N_IN'(v))
                tt_wr[v*N_OUT +: N_OUT] = resp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_HOLD;
            S_HOLD:  if (sample && k == K_LAST) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k      <= '0;
            settle <= '0;
            mode_q <= MODE_BIN;
            stim   <= '0;
            tt     <= '0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k      <= '0;
                        settle <= '0;
                        mode_q <= mode;
                        tt     <= '0;
                        pass_q <= 1'b0;
                        stim   <= map_pattern;
                    end
                end
                S_HOLD: begin
                    if (sample) begin
                        tt     <= tt_wr;
                        settle <= '0;
                        if (k != K_LAST) begin
                            k    <= k_inc;
                            stim <= map_pattern;
                        end
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                S_DONE:  pass_q <= (tt == exp_tt);
                default: ;
            endcase
        end
    end

    assign busy = (state == S_HOLD);
    assign done = (state == S_DONE);
    // exp_tt is only looked at in the DONE cycle; the verdict is then held until next start
    assign pass = (state == S_DONE) ? (tt == exp_tt) : pass_q;

endmodule
